// File: rtl/mmio_sd_bridge.sv
// mmio_sd_bridge: MMIO page decode bridging RAM, synchronised buttons, an SD response FIFO and an SD command handshake
module mmio_sd_bridge #(
  parameter int ADDR_W     = 12,
  parameter int BTN_W      = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int CMD_W      = 48
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       dataIn,
  input  logic              writeEnable,
  input  logic              readEnable,
  output logic [31:0]       dataOut,
  input  logic [31:0]       RAM_out,
  output logic              RAM_write,
  input  logic [BTN_W-1:0]  BTN,
  input  logic              SD_responseByte,
  input  logic [7:0]        SD_response,
  output logic [CMD_W-1:0]  SD_cmd,
  output logic              SD_start,
  input  logic              SD_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state;
  logic io, wr_io, valid, full, pop, flush, push, drop, start_req, ovf, col;
  logic [2:0] off;
  logic [BTN_W-1:0] s1, s2, flags;
  logic [7:0] mem [FIFO_DEPTH];
  logic [7:0] head;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [31:0] rd;
  logic unused_addr;
  assign io = addr[ADDR_W-1];
  assign off = addr[2:0];
  assign unused_addr = ^addr[ADDR_W-2:3];
  assign wr_io = writeEnable & io;
  assign RAM_write = writeEnable & ~io;
  assign valid = cnt != '0;
  assign full = cnt == CW'(FIFO_DEPTH);
  assign head = valid ? mem[rp] : 8'hFF;
  assign pop = io & readEnable & (off == 3'd2) & valid;
  assign flush = wr_io & (off == 3'd3) & dataIn[1];
  assign push = SD_responseByte & ~flush & (~full | pop);
  assign drop = SD_responseByte & ~flush & full & ~pop;
  assign start_req = wr_io & (off == 3'd5) & dataIn[31];
  // Button synchroniser and sticky rising-edge flags; a new edge beats a clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      flags <= '0;
    end else begin
      s1 <= BTN;
      s2 <= s1;
      flags <= (flags & ~((wr_io && off == 3'd1) ? dataIn[BTN_W-1:0] : '0)) | (s1 & ~s2);
    end
  end
  // FIFO pointers and occupancy; a flush wins over any push or pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  // FIFO storage holds data only, so it needs no reset
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= SD_response;
  end
  // Sticky status bits; setting beats clearing in the same cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
      col <= 1'b0;
    end else begin
      ovf <= (ovf & ~(wr_io && off == 3'd3 && dataIn[0])) | drop;
      col <= (col & ~(wr_io && off == 3'd3 && dataIn[2])) |
             (state == PENDING && wr_io && (off == 3'd4 || off == 3'd5));
    end
  end
  // Command FSM: the command is writable only while idle, SD_start mirrors PENDING
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      SD_cmd <= '0;
      SD_start <= 1'b0;
    end else if (state == IDLE) begin
      if (wr_io && off == 3'd4) SD_cmd[31:0] <= dataIn;
      if (wr_io && off == 3'd5) SD_cmd[CMD_W-1:32] <= dataIn[CMD_W-33:0];
      if (start_req) begin
        state <= PENDING;
        SD_start <= 1'b1;
      end
    end else if (SD_ready) begin
      state <= IDLE;
      SD_start <= 1'b0;
    end
  end
  // Read mux: I/O page registers or RAM pass-through
  always_comb begin
    rd = '0;
    case (off)
      3'd0: rd = 32'(s2);
      3'd1: rd = 32'(flags);
      3'd2: rd = {valid, 23'b0, head};
      3'd3: rd = {ovf, col, 13'b0, state == PENDING, 16'(cnt)};
      3'd4: rd = SD_cmd[31:0];
      3'd5: rd = {state == PENDING, 15'b0, 16'(SD_cmd >> 32)};
      default: rd = '0;
    endcase
    dataOut = io ? rd : RAM_out;
  end
endmodule

// File: tb/tb_mmio_sd_bridge.sv
// tb_mmio_sd_bridge: directed and randomized checks against a queue-based behavioural model
module tb_mmio_sd_bridge;
  logic clock = 0, reset_n = 1;
  logic [11:0] addr = 0;
  logic [31:0] dataIn = 0, RAM_out = 0, dataOut;
  logic writeEnable = 0, readEnable = 0, RAM_write;
  logic [4:0] BTN = 0;
  logic SD_responseByte = 0;
  logic [7:0] SD_response = 0;
  logic [47:0] SD_cmd;
  logic SD_start, SD_ready = 0;
  int vec = 0, err = 0;

  logic [7:0] q[$];
  logic m_ovf = 0, m_col = 0, m_pend = 0;
  logic [47:0] m_cmd = 0;
  logic [4:0] m_flags = 0, h0 = 0, h1 = 0, rise;
  logic wio, drop;
  logic [2:0] o;

  always #5 clock = ~clock;

  mmio_sd_bridge dut (
    .clock(clock), .reset_n(reset_n), .addr(addr), .dataIn(dataIn),
    .writeEnable(writeEnable), .readEnable(readEnable), .dataOut(dataOut),
    .RAM_out(RAM_out), .RAM_write(RAM_write), .BTN(BTN),
    .SD_responseByte(SD_responseByte), .SD_response(SD_response),
    .SD_cmd(SD_cmd), .SD_start(SD_start), .SD_ready(SD_ready)
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vec++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] exp_dout();
    if (!addr[11]) return RAM_out;
    case (addr[2:0])
      3'd0: return {27'b0, h1};
      3'd1: return {27'b0, m_flags};
      3'd2: return q.size() > 0 ? {1'b1, 23'b0, q[0]} : 32'hFF;
      3'd3: return {m_ovf, m_col, 13'b0, m_pend, 16'(q.size())};
      3'd4: return m_cmd[31:0];
      3'd5: return {m_pend, 15'b0, m_cmd[47:32]};
      default: return 32'h0;
    endcase
  endfunction

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      q.delete();
      m_ovf = 0; m_col = 0; m_pend = 0; m_cmd = 0; m_flags = 0; h0 = 0; h1 = 0;
    end else begin
      o = addr[2:0];
      wio = writeEnable & addr[11];
      rise = h0 & ~h1;
      m_flags = (m_flags & ~((wio && o == 1) ? dataIn[4:0] : 5'd0)) | rise;
      h1 = h0;
      h0 = BTN;
      drop = 0;
      if (wio && o == 3 && dataIn[1]) q.delete();
      else begin
        if (addr[11] && readEnable && o == 2 && q.size() > 0) void'(q.pop_front());
        if (SD_responseByte) begin
          if (q.size() < 8) q.push_back(SD_response);
          else drop = 1;
        end
      end
      if (wio && o == 3 && dataIn[0]) m_ovf = 0;
      if (drop) m_ovf = 1;
      if (wio && o == 3 && dataIn[2]) m_col = 0;
      if (m_pend && wio && (o == 4 || o == 5)) m_col = 1;
      if (m_pend) begin
        if (SD_ready) m_pend = 0;
      end else if (wio) begin
        if (o == 4) m_cmd[31:0] = dataIn;
        if (o == 5) begin
          m_cmd[47:32] = dataIn[15:0];
          if (dataIn[31]) m_pend = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    chk("dataOut", dataOut, exp_dout());
    chk("RAM_write", RAM_write, writeEnable & ~addr[11]);
    chk("SD_cmd", SD_cmd, m_cmd);
    chk("SD_start", SD_start, m_pend);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = {1'b1, 8'h0, a};
    dataIn = d;
    writeEnable = 1;
    step();
    writeEnable = 0;
  endtask

  task automatic rd(input string n, input logic [2:0] a, input logic [31:0] e, input logic p);
    addr = {1'b1, 8'h0, a};
    readEnable = p;
    #3 chk(n, dataOut, e);
    step();
    readEnable = 0;
  endtask

  task automatic pulse(input logic [7:0] b);
    SD_responseByte = 1;
    SD_response = b;
    step();
    SD_responseByte = 0;
  endtask

  initial begin
    #1 reset_n = 0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1;
    rd("rst_off2", 2, 32'hFF, 0);
    rd("rst_off3", 3, 32'h0, 0);
    chk("rst_start", SD_start, 0);
    for (int i = 1; i <= 9; i++) pulse(8'(i));
    rd("ovf_cnt", 3, 32'h80000008, 0);
    for (int i = 1; i <= 8; i++) rd("pop", 2, 32'h80000000 | i, 1);
    rd("pop_empty", 2, 32'hFF, 1);
    wr(3, 32'h1);
    rd("ovf_clr", 3, 32'h0, 0);
    wr(4, 32'hDEADBEEF);
    wr(5, 32'h80001234);
    chk("cmd", SD_cmd, 48'h1234DEADBEEF);
    chk("start_hi", SD_start, 1);
    wr(4, 32'h11111111);
    chk("cmd_hold", SD_cmd, 48'h1234DEADBEEF);
    rd("col", 3, 32'h40010000, 0);
    rd("off5", 5, 32'h80001234, 0);
    SD_ready = 1;
    #3 chk("start_held", SD_start, 1);
    step();
    SD_ready = 0;
    chk("start_lo", SD_start, 0);
    wr(3, 32'h4);
    rd("col_clr", 3, 32'h0, 0);
    addr = 12'h800;
    BTN = 5'b00100;
    #3 chk("btn_lat0", dataOut, 0);
    step();
    #3 chk("btn_lat1", dataOut, 0);
    step();
    rd("btn_sync", 0, 32'h4, 0);
    rd("btn_flag", 1, 32'h4, 0);
    wr(1, 32'h4);
    rd("flag_clr", 1, 32'h0, 0);
    pulse(8'hA1); pulse(8'hA2); pulse(8'hA3);
    SD_responseByte = 1;
    SD_response = 8'hA4;
    rd("pp_head", 2, 32'h800000A1, 1);
    SD_responseByte = 0;
    rd("pp_cnt", 3, 32'h3, 0);
    rd("pp_b", 2, 32'h800000A2, 1);
    rd("pp_c", 2, 32'h800000A3, 1);
    rd("pp_d", 2, 32'h800000A4, 1);
    wr(5, 32'h80000000);
    chk("start2", SD_start, 1);
    pulse(8'h05); pulse(8'h06);
    addr = 12'h803;
    reset_n = 0;
    #1 chk("rst_async_start", SD_start, 0);
    chk("rst_async_cnt", dataOut, 0);
    #1 reset_n = 1;
    step();
    addr = 12'h123;
    RAM_out = $urandom;
    writeEnable = 1;
    #3 chk("ram_rd", dataOut, RAM_out);
    chk("ram_we", RAM_write, 1);
    step();
    writeEnable = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        reset_n = 0;
        #2 reset_n = 1;
      end
      addr = {($urandom_range(3) != 0), 8'($urandom), 3'($urandom)};
      dataIn = $urandom;
      if (addr[2:0] == 3 && $urandom_range(3) != 0) dataIn[1] = 0;
      writeEnable = $urandom_range(9) < 3;
      readEnable = $urandom_range(9) < 4;
      SD_responseByte = $urandom_range(9) < 4;
      SD_response = 8'($urandom);
      SD_ready = $urandom_range(4) == 0;
      if ($urandom_range(9) == 0) BTN = 5'($urandom);
      RAM_out = $urandom;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
